eth_tx_sched: RTL

Frame scheduler that shares the single `eth_tx2` transmitter and its 1 KiB frame BRAM between `N_REQ` frame producers. It grants one producer at a time exclusive write access to the BRAM and latches the frame length it reports. It then kicks `eth_tx2` with `start_stb`/`tx_len` and holds the grant until transmission finishes. Arbitration is round-robin, with a hold-timeout watchdog and length checking. The block sits between the producers (ARP/UDP/test generators) and `eth_tx2`.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/eth_tx_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
// Frame BRAM geometry and scheduler state encoding.
package eth_pkg;

  localparam int ETH_BRAM_AW = 10;
  localparam int ETH_LEN_W   = 11;
  localparam int ETH_LEN_MAX = 1024;
  localparam int ETH_DATA_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_KICK,
    S_WAIT
  } sched_st_e;

  function automatic logic len_ok(
    input logic [ETH_LEN_W-1:0] l,
    input int unsigned          lim
  );
    return (l != '0) && (32'(l) <= lim);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after
// the last winner, in circular order.
module rr_arbiter #(
  parameter  int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares one eth_tx2 transmitter and its frame BRAM among
// N_REQ producers with round-robin grants and a hold watchdog.
import eth_pkg::*;

module eth_tx_sched #(
  parameter int N_REQ        = 2,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int LEN_MAX      = ETH_LEN_MAX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_stb,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              done,
  input  logic [N_REQ*ETH_LEN_W-1:0]    len,
  input  logic [N_REQ-1:0]              wr_en,
  input  logic [N_REQ*ETH_BRAM_AW-1:0]  wr_addr,
  input  logic [N_REQ*ETH_DATA_W-1:0]   wr_data,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              err,
  output logic                          bram_wr_en,
  output logic [ETH_BRAM_AW-1:0]        bram_wr_addr,
  output logic [ETH_DATA_W-1:0]         bram_wr_data,
  output logic                          start_stb,
  output logic [ETH_LEN_W-1:0]          tx_len,
  input  logic                          tx_busy,
  output logic [15:0]                   frame_cnt
);

  localparam int GW = $clog2(N_REQ);

  sched_st_e            state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     err_q, err_d;
  logic                 start_q, start_d;
  logic [ETH_LEN_W-1:0] tx_len_q, tx_len_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          hold_q, hold_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        gidx_q, gidx_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [GW-1:0]        arb_idx;
  logic                 arb_any;
  logic [ETH_LEN_W-1:0] glen;
  logic                 revoke;

  // eth_tx2 latches start_stb on its own strobe; holding
  // start_stb until tx_busy makes the strobe irrelevant here.
  logic unused_clk_stb;
  assign unused_clk_stb = clk_stb;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign glen = len[ETH_LEN_W*int'(gidx_q) +: ETH_LEN_W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    start_d  = start_q;
    tx_len_d = tx_len_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    revoke   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (arb_any && !tx_busy) begin
          state_d = S_GRANT;
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          last_d  = arb_idx;
          hold_d  = '0;
        end
      end
      (state_q == S_GRANT): begin
        hold_d = hold_q + 16'd1;
        // done beats a simultaneous req drop
        if (done[gidx_q]) begin
          if (len_ok(glen, LEN_MAX)) begin
            state_d  = S_KICK;
            tx_len_d = glen;
            start_d  = 1'b1;
          end else begin
            revoke = 1'b1;
          end
        end else if (!req[gidx_q]) begin
          revoke = 1'b1;
        end else if (hold_q == 16'(HOLD_TIMEOUT - 1)) begin
          revoke = 1'b1;
        end
        if (revoke) begin
          state_d = S_IDLE;
          grant_d = '0;
          err_d   = grant_q;
        end
      end
      (state_q == S_KICK): begin
        if (tx_busy) begin
          state_d = S_WAIT;
          start_d = 1'b0;
        end
      end
      (state_q == S_WAIT): begin
        if (!tx_busy) begin
          state_d = S_IDLE;
          grant_d = '0;
          ack_d   = grant_q;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      tx_len_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      last_q   <= GW'(N_REQ - 1);
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      start_q  <= start_d;
      tx_len_q <= tx_len_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
    end
  end

  always_comb begin
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    if (|grant_q) begin
      bram_wr_addr = wr_addr[ETH_BRAM_AW*int'(gidx_q) +: ETH_BRAM_AW];
      bram_wr_data = wr_data[ETH_DATA_W*int'(gidx_q) +: ETH_DATA_W];
      bram_wr_en   = (state_q == S_GRANT) && wr_en[gidx_q];
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign start_stb = start_q;
  assign tx_len    = tx_len_q;
  assign frame_cnt = cnt_q;

endmodule
